// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path for the clk_5m domain.
// Oversamples rx on a 16x-baud clock enable, deframes start/8 data (LSB first)/stop,
// and holds each byte in dout with a rdy/rdy_clr handshake plus framing-error and
// overrun status.
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_5m,
    input  logic       rst,
    input  logic       rx,
    input  logic       clken,
    input  logic       rdy_clr,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic                   r_rx_last;
    logic                   w_rx_last_nx;
    logic [3:0]             r_sample;
    logic [3:0]             w_sample_nx;
    logic [2:0]             r_bitpos;
    logic [2:0]             w_bitpos_nx;
    logic [7:0]             r_scratch;
    logic [7:0]             w_scratch_nx;
    logic                   w_done;
    logic [7:0]             r_dout;
    logic                   r_rdy;
    logic                   r_frame_err;
    logic                   r_overrun;

    assign w_rx_s    = r_sync[SYNC_STAGES-1];
    assign dout      = r_dout;
    assign rdy       = r_rdy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign rx_busy   = (r_state != IDLE);

    // Bring the asynchronous line into clk_5m; idles high so reset looks like an idle line.
    always_ff @(posedge clk_5m or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    // State, oversample counters and shift scratch register.
    always_ff @(posedge clk_5m or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rx_last <= 1'b1;
            r_sample  <= 4'd0;
            r_bitpos  <= 3'd0;
            r_scratch <= 8'h00;
        end else begin
            r_state   <= w_state_nx;
            r_rx_last <= w_rx_last_nx;
            r_sample  <= w_sample_nx;
            r_bitpos  <= w_bitpos_nx;
            r_scratch <= w_scratch_nx;
        end
    end

    // Next-state logic; everything advances only on 16x-baud enable cycles.
    always_comb begin
        w_state_nx   = r_state;
        w_rx_last_nx = r_rx_last;
        w_sample_nx  = r_sample;
        w_bitpos_nx  = r_bitpos;
        w_scratch_nx = r_scratch;
        w_done       = 1'b0;
        if (clken) begin
            case (r_state)
                IDLE: begin
                    // Edge detect, so a line stuck low (break) never retriggers.
                    w_rx_last_nx = w_rx_s;
                    if (r_rx_last && !w_rx_s) begin
                        w_state_nx  = START;
                        w_sample_nx = 4'd0;
                    end
                end
                START: begin
                    if (r_sample == 4'd7) begin
                        if (!w_rx_s) begin
                            w_state_nx  = DATA;
                            w_sample_nx = 4'd0;
                            w_bitpos_nx = 3'd0;
                        end else begin
                            // Low pulse did not last to mid-bit: treat as a glitch.
                            w_state_nx   = IDLE;
                            w_rx_last_nx = w_rx_s;
                        end
                    end else begin
                        w_sample_nx = r_sample + 4'd1;
                    end
                end
                DATA: begin
                    if (r_sample == 4'd15) begin
                        w_scratch_nx[r_bitpos] = w_rx_s;
                        w_sample_nx            = 4'd0;
                        if (r_bitpos == 3'd7) begin
                            w_state_nx = STOP;
                        end else begin
                            w_bitpos_nx = r_bitpos + 3'd1;
                        end
                    end else begin
                        w_sample_nx = r_sample + 4'd1;
                    end
                end
                STOP: begin
                    if (r_sample == 4'd15) begin
                        // Frame complete; rx_last captures a low stop so a break needs a rising edge first.
                        w_done       = 1'b1;
                        w_state_nx   = IDLE;
                        w_rx_last_nx = w_rx_s;
                        w_sample_nx  = 4'd0;
                    end else begin
                        w_sample_nx = r_sample + 4'd1;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    // Holding register and handshake flags; a completing frame wins over rdy_clr.
    always_ff @(posedge clk_5m or posedge rst) begin
        if (rst) begin
            r_dout      <= 8'h00;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_done) begin
                r_dout      <= r_scratch;
                r_frame_err <= ~w_rx_s;
            end
            if (w_done) begin
                r_rdy <= 1'b1;
            end else if (rdy_clr) begin
                r_rdy <= 1'b0;
            end
            if (rdy_clr) begin
                r_overrun <= 1'b0;
            end else if (w_done && r_rdy) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver. Expected bytes and flags are
// queued as frames are sent and popped once the receiver has finished each frame.
module tb_uart_receiver;

    localparam int CLKDIV = 4;
    localparam int BITCK  = 16;

    logic       clk_5m = 1'b0;
    logic       rst;
    logic       rx;
    logic       clken;
    logic       rdy_clr;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int div_cnt  = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    uart_receiver #(.SYNC_STAGES(2)) dut (
        .clk_5m    (clk_5m),
        .rst       (rst),
        .rx        (rx),
        .clken     (clken),
        .rdy_clr   (rdy_clr),
        .dout      (dout),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk_5m = ~clk_5m;

    // 16x-baud enable: one clk_5m cycle in every CLKDIV, changed on the falling edge.
    initial begin
        clken = 1'b0;
        forever begin
            @(negedge clk_5m);
            div_cnt = (div_cnt == CLKDIV - 1) ? 0 : div_cnt + 1;
            clken   = (div_cnt == CLKDIV - 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_clken();
        @(posedge clk_5m);
        while (!clken) @(posedge clk_5m);
    endtask

    task automatic pulse_clr();
        @(negedge clk_5m);
        rdy_clr = 1'b1;
        @(negedge clk_5m);
        rdy_clr = 1'b0;
    endtask

    // Send one frame at 16 clken per bit. clr_at>0 raises rdy_clr for exactly the
    // clk_5m cycle of the clr_at-th clken after the start bit is driven.
    task automatic send_frame(input logic [7:0] b, input logic stop_hi, input int clr_at);
        logic [9:0] bits;
        int k;
        bits = {stop_hi, b, 1'b0};
        k = 0;
        wait_clken();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_5m);
            rx = bits[i];
            for (int j = 0; j < BITCK; j++) begin
                if (clr_at > 0 && k == clr_at - 1) begin
                    repeat (CLKDIV - 1) @(posedge clk_5m);
                    @(negedge clk_5m);
                    rdy_clr = 1'b1;
                end
                wait_clken();
                k++;
                if (clr_at > 0 && k == clr_at) begin
                    @(negedge clk_5m);
                    rdy_clr = 1'b0;
                end
            end
        end
        @(negedge clk_5m);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!rx_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_5m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rdy_clr = 1'b0;
        repeat (5) @(negedge clk_5m);
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_checks++; if ({rdy, frame_err, overrun, rx_busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {rdy, frame_err, overrun, rx_busy}); end
        rst = 1'b0;
        repeat (10) wait_clken();
        @(negedge clk_5m);
    endtask

    task automatic test_single_byte();
        bit ok;
        sb.push_back('{d: 8'hA5, fe: 1'b0, ov: 1'b0});
        send_frame(8'hA5, 1'b1, 0);
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL a5_idle: rx_busy got 1 want 0"); end
        e = sb.pop_front();
        n_checks++; if (dout !== e.d) begin n_fail++; $display("FAIL a5_dout: got %h want %h", dout, e.d); end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL a5_rdy: got %b want 1", rdy); end
        n_checks++; if (frame_err !== e.fe) begin n_fail++; $display("FAIL a5_ferr: got %b want %b", frame_err, e.fe); end
        n_checks++; if (overrun !== e.ov) begin n_fail++; $display("FAIL a5_ovr: got %b want %b", overrun, e.ov); end
        pulse_clr();
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL a5_clr: rdy got %b want 0", rdy); end
    endtask

    task automatic test_glitch();
        wait_clken();
        @(negedge clk_5m);
        rx = 1'b0;
        repeat (4) wait_clken();
        @(negedge clk_5m);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b want 1", rx_busy); end
        rx = 1'b1;
        repeat (20) wait_clken();
        @(negedge clk_5m);
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: rx_busy got %b want 0", rx_busy); end
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_rdy: got %b want 0", rdy); end
        n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL glitch_dout: got %h want a5", dout); end
    endtask

    task automatic test_framing_break();
        bit ok;
        int busy_seen;
        sb.push_back('{d: 8'h3C, fe: 1'b1, ov: 1'b0});
        send_frame(8'h3C, 1'b0, 0);
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fe_idle: rx_busy got 1 want 0"); end
        e = sb.pop_front();
        n_checks++; if (dout !== e.d) begin n_fail++; $display("FAIL fe_dout: got %h want %h", dout, e.d); end
        n_checks++; if (frame_err !== e.fe) begin n_fail++; $display("FAIL fe_ferr: got %b want %b", frame_err, e.fe); end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL fe_rdy: got %b want 1", rdy); end
        busy_seen = 0;
        for (int i = 0; i < 40 * BITCK; i++) begin
            wait_clken();
            @(negedge clk_5m);
            if (rx_busy) busy_seen++;
        end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL break_retrigger: busy cycles got %0d want 0", busy_seen); end
        n_checks++; if (overrun !== 1'b0 || dout !== 8'h3C) begin n_fail++; $display("FAIL break_hold: ovr/dout got %b/%h want 0/3c", overrun, dout); end
        pulse_clr();
        rx = 1'b1;
        repeat (BITCK) wait_clken();
        sb.push_back('{d: 8'h81, fe: 1'b0, ov: 1'b0});
        send_frame(8'h81, 1'b1, 0);
        wait_idle(ok);
        e = sb.pop_front();
        n_checks++; if (dout !== e.d) begin n_fail++; $display("FAIL post_break_dout: got %h want %h", dout, e.d); end
        n_checks++; if (frame_err !== e.fe) begin n_fail++; $display("FAIL post_break_ferr: got %b want %b", frame_err, e.fe); end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL post_break_rdy: got %b want 1", rdy); end
        pulse_clr();
    endtask

    task automatic test_back_to_back();
        bit ok;
        sb.push_back('{d: 8'h11, fe: 1'b0, ov: 1'b0});
        send_frame(8'h11, 1'b1, 0);
        e = sb.pop_front();
        n_checks++; if (dout !== e.d || overrun !== e.ov) begin n_fail++; $display("FAIL b2b_first: dout/ovr got %h/%b want %h/%b", dout, overrun, e.d, e.ov); end
        sb.push_back('{d: 8'h22, fe: 1'b0, ov: 1'b1});
        send_frame(8'h22, 1'b1, 0);
        wait_idle(ok);
        e = sb.pop_front();
        n_checks++; if (dout !== e.d) begin n_fail++; $display("FAIL b2b_dout: got %h want %h", dout, e.d); end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy: got %b want 1", rdy); end
        n_checks++; if (overrun !== e.ov) begin n_fail++; $display("FAIL b2b_ovr: got %b want %b", overrun, e.ov); end
        pulse_clr();
        n_checks++; if ({rdy, overrun} !== 2'b00) begin n_fail++; $display("FAIL b2b_clr: rdy/ovr got %b want 00", {rdy, overrun}); end
    endtask

    task automatic test_clear_race();
        bit ok;
        sb.push_back('{d: 8'h11, fe: 1'b0, ov: 1'b0});
        send_frame(8'h11, 1'b1, 0);
        e = sb.pop_front();
        n_checks++; if (dout !== e.d || rdy !== 1'b1) begin n_fail++; $display("FAIL race_first: dout/rdy got %h/%b want %h/1", dout, rdy, e.d); end
        // Start edge is seen on clken 1, mid-start on 9, stop sampled on 9+16*9 = 153.
        sb.push_back('{d: 8'h22, fe: 1'b0, ov: 1'b0});
        send_frame(8'h22, 1'b1, 153);
        wait_idle(ok);
        e = sb.pop_front();
        n_checks++; if (dout !== e.d) begin n_fail++; $display("FAIL race_dout: got %h want %h", dout, e.d); end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL race_rdy: got %b want 1", rdy); end
        n_checks++; if (overrun !== e.ov) begin n_fail++; $display("FAIL race_ovr: got %b want %b", overrun, e.ov); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [7:0] b;
        b = 8'h5A;
        wait_clken();
        @(negedge clk_5m);
        rx = 1'b0;
        repeat (BITCK) wait_clken();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_5m);
            rx = b[i];
            repeat (BITCK) wait_clken();
        end
        @(negedge clk_5m);
        rx = b[3];
        repeat (BITCK / 2) wait_clken();
        @(negedge clk_5m);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b want 1", rx_busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rstmid_dout: got %h want 00", dout); end
        n_checks++; if ({rdy, frame_err, overrun, rx_busy} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 0000", {rdy, frame_err, overrun, rx_busy}); end
        rx = 1'b1;
        repeat (4) @(negedge clk_5m);
        rst = 1'b0;
        repeat (20) wait_clken();
        @(negedge clk_5m);
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_nopartial: rdy got %b want 0", rdy); end
        sb.push_back('{d: 8'h5A, fe: 1'b0, ov: 1'b0});
        send_frame(8'h5A, 1'b1, 0);
        wait_idle(ok);
        e = sb.pop_front();
        n_checks++; if (dout !== e.d) begin n_fail++; $display("FAIL rstmid_5a_dout: got %h want %h", dout, e.d); end
        n_checks++; if (rdy !== 1'b1 || overrun !== e.ov) begin n_fail++; $display("FAIL rstmid_5a_flags: rdy/ovr got %b/%b want 1/%b", rdy, overrun, e.ov); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing_break();
        test_back_to_back();
        test_clear_race();
        test_reset_mid_frame();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
